// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and parity modes for the UART transmitter
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    PAR   = 5'b01000,
    STOP  = 5'b10000
  } state_t;
endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: valid/ready word handshake into the transmit FIFO
interface uart_tx_cfg_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, tick on the last cycle of each bit, held at zero by clear
module uart_baud_gen #(
  parameter int BAUD_DIV = 868
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(BAUD_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(BAUD_DIV - 1);
  always_ff @(posedge CLK100MHZ or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clear || tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: FIFO-buffered UART transmitter with configurable data, parity and stop bits
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic CLK100MHZ,
  input  logic reset,
  uart_tx_cfg_if.slave tx,
  output logic UART_RXD_OUT,
  output logic busy,
  output logic done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  state_t state, state_n;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] sh, sh_n, head;
  logic [AW-1:0] wp, rp;
  logic [3:0] idx, idx_n;
  logic par, par_n, line_n, en, tick, push, pop, empty;
  assign empty = fifo_count == '0;
  assign head = mem[rp];
  assign tx.tx_ready = en && fifo_count != FULL;
  assign push = tx.tx_valid && tx.tx_ready;
  assign busy = state != IDLE;
  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .clear(state == IDLE),
    .tick(tick)
  );
  // idx counts data bits in DATA and stop bits in STOP; a pop from IDLE or STOP reloads the frame
  always_comb begin
    state_n = state;
    sh_n = sh;
    idx_n = idx;
    par_n = par;
    pop = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: pop = !empty;
      START: state_n = tick ? DATA : START;
      DATA: if (tick) begin
        sh_n = sh >> 1;
        idx_n = idx == LAST_D ? '0 : idx + 4'd1;
        state_n = idx != LAST_D ? DATA : PARITY != PAR_NONE ? PAR : STOP;
      end
      PAR: state_n = tick ? STOP : PAR;
      STOP: if (tick) begin
        done = idx == LAST_S;
        idx_n = done ? '0 : idx + 4'd1;
        pop = done && !empty;
        state_n = !done ? STOP : empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      sh_n = head;
      idx_n = '0;
      par_n = ^head ^ (PARITY == PAR_ODD);
      state_n = START;
    end
    line_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PAR ? par_n : 1'b1;
  end
  always_ff @(posedge CLK100MHZ or posedge reset)
    if (reset) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      par <= 1'b0;
      UART_RXD_OUT <= 1'b1;
      en <= 1'b0;
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      idx <= idx_n;
      par <= par_n;
      UART_RXD_OUT <= line_n;
      en <= 1'b1;
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge CLK100MHZ)
    if (push) mem[wp] <= tx.tx_data;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: three configurations checked every cycle against a frame-level queue model
module tb_uart_tx_cfg;
  localparam int PB [3] = '{4, 4, 868};
  localparam int PD [3] = '{8, 7, 8};
  localparam int PP [3] = '{0, 2, 0};
  localparam int PS [3] = '{1, 2, 1};
  localparam int DEPTH = 4;
  logic CLK100MHZ = 1'b0;
  logic reset = 1'b1;
  always #5 CLK100MHZ = ~CLK100MHZ;
  logic val [3];
  int dat [3];
  logic [2:0] line, busy, done, rdy;
  logic [2:0] cnt [3];
  uart_tx_cfg_if #(.DATA_BITS(8)) ia ();
  uart_tx_cfg_if #(.DATA_BITS(7)) ib ();
  uart_tx_cfg_if #(.DATA_BITS(8)) ic ();
  assign ia.tx_valid = val[0];
  assign ib.tx_valid = val[1];
  assign ic.tx_valid = val[2];
  assign ia.tx_data = 8'(dat[0]);
  assign ib.tx_data = 7'(dat[1]);
  assign ic.tx_data = 8'(dat[2]);
  assign rdy = {ic.tx_ready, ib.tx_ready, ia.tx_ready};
  uart_tx_cfg #(.BAUD_DIV(4)) ua (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .tx(ia),
    .UART_RXD_OUT(line[0]), .busy(busy[0]), .done(done[0]), .fifo_count(cnt[0])
  );
  uart_tx_cfg #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) ub (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .tx(ib),
    .UART_RXD_OUT(line[1]), .busy(busy[1]), .done(done[1]), .fifo_count(cnt[1])
  );
  uart_tx_cfg uc (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .tx(ic),
    .UART_RXD_OUT(line[2]), .busy(busy[2]), .done(done[2]), .fifo_count(cnt[2])
  );
  int q [3][$];
  int rem [3];
  int cur [3];
  bit en [3];
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int frame(input int i);
    return (1 + PD[i] + (PP[i] != 0 ? 1 : 0) + PS[i]) * PB[i];
  endfunction
  // rem counts cycles left in the frame on the line; 0 means idle
  function automatic int exp_line(input int i);
    int b;
    if (rem[i] == 0) return 1;
    b = (frame(i) - rem[i]) / PB[i];
    if (b == 0) return 0;
    if (b <= PD[i]) return (cur[i] >> (b - 1)) & 1;
    if (b == PD[i] + 1 && PP[i] != 0) return ($countones(cur[i]) & 1) ^ (PP[i] == 2 ? 1 : 0);
    return 1;
  endfunction
  task automatic step(input int i);
    bit r, p;
    if (reset) begin
      q[i].delete();
      rem[i] = 0;
      en[i] = 0;
      return;
    end
    r = en[i] && q[i].size() < DEPTH;
    p = q[i].size() != 0 && rem[i] <= 1;
    if (p) begin
      cur[i] = q[i].pop_front();
      rem[i] = frame(i);
    end else if (rem[i] > 0) rem[i]--;
    if (val[i] && r) q[i].push_back(dat[i] & ((1 << PD[i]) - 1));
    en[i] = 1;
  endtask
  always @(posedge CLK100MHZ) for (int i = 0; i < 3; i++) step(i);
  always @(negedge CLK100MHZ)
    for (int i = 0; i < 3; i++) begin
      check($sformatf("line%0d", i), 32'(line[i]), 32'(exp_line(i)));
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(rem[i] != 0));
      check($sformatf("done%0d", i), 32'(done[i]), 32'(rem[i] == 1));
      check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(en[i] && q[i].size() < DEPTH));
      check($sformatf("count%0d", i), 32'(cnt[i]), 32'(q[i].size()));
    end
  task automatic tick();
    @(negedge CLK100MHZ);
    #2;
  endtask
  initial begin
    int n, dens;
    for (int i = 0; i < 3; i++) begin
      val[i] = 1'b0;
      dat[i] = 0;
    end
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    dat[0] = 'hA5;
    dat[1] = 'h55;
    dat[2] = 'h0F;
    for (int i = 0; i < 3; i++) val[i] = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) val[i] = 1'b0;
    repeat (50) tick();
    val[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dat[0] = $urandom;
      tick();
    end
    val[0] = 1'b0;
    repeat (130) tick();
    val[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dat[0] = 'h30 + k;
      tick();
    end
    val[0] = 1'b0;
    repeat (220) tick();
    dens = 0;
    for (int t = 0; t < 9000; t++) begin
      if (t % 500 == 0) dens = $urandom_range(0, 16);
      for (int i = 0; i < 2; i++) begin
        val[i] = $urandom_range(0, 15) < dens;
        dat[i] = $urandom;
      end
      tick();
    end
    for (int i = 0; i < 3; i++) val[i] = 1'b0;
    n = 0;
    while ((q[0].size() != 0 || rem[0] != 0 || q[1].size() != 0 || rem[1] != 0 || rem[2] != 0) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < 3000), 1);
    repeat (5) tick();
    val[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dat[0] = $urandom;
      tick();
    end
    val[0] = 1'b0;
    n = 0;
    while (rem[0] != frame(0) - 16 && n < 200) begin
      tick();
      n++;
    end
    check("wait17_timeout", 32'(n < 200), 1);
    check("queued_before_reset", 32'(cnt[0]), 2);
    check("line_low_before_reset", 32'(line[0]), 32'(exp_line(0)));
    reset = 1'b1;
    #1;
    check("reset_line", 32'(line[0]), 1);
    check("reset_count", 32'(cnt[0]), 0);
    check("reset_done", 32'(done[0]), 0);
    check("reset_busy", 32'(busy[0]), 0);
    check("reset_ready", 32'(rdy[0]), 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (100) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter BAUD_DIV, default 868, clocks per bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..64.
REQ-006 CLK100MHZ  input  1  system clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 tx_data  input  DATA_BITS  byte/word to transmit.
REQ-009 tx_valid  input  1  tx_data is offered this cycle.
REQ-010 tx_ready  output  1  FIFO can accept a word (not full).
REQ-011 UART_RXD_OUT  output  1  serial line to host, idle high.
REQ-012 busy  output  1  a frame is on the line (state not IDLE).
REQ-013 done  output  1  one-cycle pulse at end of each frame.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued.

Function
REQ-015 Push occurs on a rising edge where tx_valid and tx_ready are both 1; tx_ready = (fifo_count != FIFO_DEPTH), evaluated before any same-cycle pop.
REQ-016 Push while full is dropped; count, contents and tx_ready stay unchanged.
REQ-017 Simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_count unchanged and preserves order.
REQ-018 FIFO read/write pointers wrap modulo FIFO_DEPTH; fifo_count saturates neither above FIFO_DEPTH nor below 0.
REQ-019 FSM states: IDLE, START, DATA, PAR, STOP.
REQ-020 IDLE: line = 1; if FIFO non-empty, pop head into shift register, clear bit index, clear baud counter, go to START.
REQ-021 START: line = 0 for exactly BAUD_DIV cycles, then DATA.
REQ-022 DATA: drive shift register LSB first, one bit per BAUD_DIV cycles, DATA_BITS bits; then PAR if PARITY != 0, else STOP.
REQ-023 PAR: line = XOR of data bits (even) or its inverse (odd), for BAUD_DIV cycles; then STOP.
REQ-024 STOP: line = 1 for STOP_BITS*BAUD_DIV cycles; on the final cycle assert done for one cycle.
REQ-025 On leaving STOP: if FIFO non-empty, pop and enter START directly (no idle gap); else IDLE.
REQ-026 Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV cycles exactly.
REQ-027 Baud counter counts 0..BAUD_DIV-1, emits bit tick at BAUD_DIV-1, held at 0 in IDLE; no free-running phase offset.
REQ-028 Line falls to 0 on the second rising edge after a push into an empty FIFO with FSM in IDLE.
REQ-029 UART_RXD_OUT is a registered output; no combinational path from inputs.
REQ-030 tx_data changes after acceptance do not affect the queued or in-flight word.

Reset
REQ-031 While reset = 1: UART_RXD_OUT = 1, done = 0, busy = 0, tx_ready = 0, FSM = IDLE, baud counter = 0, FIFO emptied (fifo_count = 0).
REQ-032 tx_ready = 1 from the first rising edge after reset deasserts.
REQ-033 Reset mid-frame aborts the frame immediately; line returns high asynchronously; queued words are discarded.

Structure
REQ-034 Shared package uart_pkg holds FSM state encoding (one-hot, 5 bits) and parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
REQ-035 Baud tick generator is a sub-module uart_baud_gen (inputs clock, reset, clear; output tick; parameter BAUD_DIV).
REQ-036 FIFO is implemented inline with registers, no vendor primitives.

Verification (BAUD_DIV = 4 unless noted)
REQ-037 8N1, push 0xA5 into idle block -> line: 0,1,0,1,0,0,1,0,1,1 each 4 cycles; done pulses once at cycle 40 of frame; busy high 40 cycles.
REQ-038 DATA_BITS=7, PARITY=2 (odd), STOP_BITS=2, push 0x55 -> start, 1010101, parity 1, two stop bits; frame 44 cycles.
REQ-039 Push 3 words back-to-back -> three contiguous frames, no high gap between stop and next start, three done pulses 40 cycles apart.
REQ-040 FIFO_DEPTH=4, hold tx_valid for 6 cycles while first frame runs -> 1 popped + 4 accepted, tx_ready low, 6th word dropped; 5 frames sent total.
REQ-041 Assert reset at cycle 17 of a frame with 2 words queued -> line high same cycle, fifo_count 0, no done pulse, no further frames.
REQ-042 BAUD_DIV=868, push 0x0F -> each bit exactly 868 cycles, frame 8680 cycles.
